// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op encodings, FSM states, helpers.
package alu_pkg;

   localparam int NIB_W = 4;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_ADC = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_SBC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_CP  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } alu_state_e;

   // 1 when the byte holds an even number of ones
   function automatic logic parity_even(input logic [7:0] v);
      return ~(^v);
   endfunction

   // Subtract-type ops run B inverted through the adder and report borrows
   function automatic logic is_sub(input logic [2:0] op);
      return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
   endfunction

endpackage

// File: rtl/alu_nib_add.sv
// Single 4-bit adder shared by the low and high passes of the ALU core.
// c3 is the carry into the top bit, needed for the overflow flag on the high pass.
module alu_nib_add #(
   parameter int NIB_W = 4
) (
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] sum,
   output logic             c3,
   output logic             cout
);

   logic [NIB_W:0]   full_sum;
   logic [NIB_W-1:0] part_sum;

   assign full_sum = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
   assign part_sum = {1'b0, a[NIB_W-2:0]} + {1'b0, b[NIB_W-2:0]} + {{(NIB_W-1){1'b0}}, cin};

   assign sum  = full_sum[NIB_W-1:0];
   assign cout = full_sum[NIB_W];
   assign c3   = part_sum[NIB_W-1];

endmodule

// File: rtl/alu_nibble_core.sv
// Nibble-serial Z80 ALU core. One 8-bit op runs as a low and a high pass
// through a single 4-bit adder; result and flags are registered on entry to DONE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on acceptance
// ST_LOW  | low-nibble pass, stores low sum and half carry c4
// ST_HIGH | high-pass, result/flags registered at exit, done raised
// ST_DONE | done pulse cycle, busy drops on return to IDLE
module alu_nibble_core #(
   parameter int NIB_W    = 4,
   parameter bit HOLD_RES = 1'b1
) (
   input  logic                 clk,
   input  logic                 nreset,
   input  logic                 start,
   input  logic [2:0]           op543,
   input  logic                 shift_mode,
   input  logic [2*NIB_W-1:0]   acc,
   input  logic [NIB_W-1:0]     db_in_low,
   input  logic [NIB_W-1:0]     db_in_high,
   input  logic                 cf_shift,
   input  logic                 cf_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*NIB_W-1:0]   result,
   output logic                 sf,
   output logic                 zf,
   output logic                 hf,
   output logic                 pvf,
   output logic                 nf,
   output logic                 cf
);

   import alu_pkg::*;

   localparam int BW = 2 * NIB_W;

   alu_state_e       state_q;
   logic [BW-1:0]    a_q;
   logic [BW-1:0]    b_q;
   logic [2:0]       op_q;
   logic             shift_q;
   logic             cf_shift_q;
   logic             cf_in_q;
   logic [NIB_W-1:0] lo_sum_q;
   logic             c4_q;
   logic             busy_q;
   logic             done_q;
   logic [BW-1:0]    result_q;
   logic             sf_q, zf_q, hf_q, pvf_q, nf_q, cf_q;

   logic             sub_op;
   logic             k0;
   logic [BW-1:0]    b_eff;
   logic [NIB_W-1:0] add_a, add_b, add_sum;
   logic             add_cin, add_c3, add_cout;
   logic [BW-1:0]    logic_res;

   logic [BW-1:0]    res_d;
   logic             wr_res_d;
   logic             sf_d, zf_d, hf_d, pvf_d, nf_d, cf_d;

   // Adder operand and carry-in selection: low nibble in LOW, high nibble chained on c4 in HIGH
   always_comb begin
      sub_op = is_sub(op_q);
      b_eff  = sub_op ? ~b_q : b_q;
      case (op_q)
         OP_ADC:        k0 = cf_in_q;
         OP_SUB, OP_CP: k0 = 1'b1;
         OP_SBC:        k0 = ~cf_in_q;
         default:       k0 = 1'b0;
      endcase
      if (state_q == ST_HIGH) begin
         add_a   = a_q[BW-1:NIB_W];
         add_b   = b_eff[BW-1:NIB_W];
         add_cin = c4_q;
      end else begin
         add_a   = a_q[NIB_W-1:0];
         add_b   = b_eff[NIB_W-1:0];
         add_cin = k0;
      end
   end

   alu_nib_add #(
      .NIB_W (NIB_W)
   ) u_nib_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .c3   (add_c3),
      .cout (add_cout)
   );

   // Final result and flags, evaluated during the HIGH pass
   always_comb begin
      case (op_q)
         OP_AND:  logic_res = a_q & b_q;
         OP_XOR:  logic_res = a_q ^ b_q;
         OP_OR:   logic_res = a_q | b_q;
         default: logic_res = '0;
      endcase

      res_d    = {add_sum, lo_sum_q};
      hf_d     = c4_q ^ sub_op;
      cf_d     = add_cout ^ sub_op;
      pvf_d    = add_c3 ^ add_cout;
      nf_d     = sub_op;
      wr_res_d = (op_q != OP_CP);

      if (shift_q) begin
         res_d    = b_q;
         cf_d     = cf_shift_q;
         hf_d     = 1'b0;
         nf_d     = 1'b0;
         pvf_d    = parity_even(b_q);
         wr_res_d = 1'b1;
      end else if (op_q[2] && (op_q != OP_CP)) begin
         res_d    = logic_res;
         cf_d     = 1'b0;
         hf_d     = (op_q == OP_AND);
         nf_d     = 1'b0;
         pvf_d    = parity_even(logic_res);
      end

      sf_d = res_d[BW-1];
      zf_d = (res_d == '0);
   end

   // Sequencer FSM with registered handshake, result and flags
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q    <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= OP_ADD;
         shift_q    <= 1'b0;
         cf_shift_q <= 1'b0;
         cf_in_q    <= 1'b0;
         lo_sum_q   <= '0;
         c4_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         sf_q       <= 1'b0;
         zf_q       <= 1'b0;
         hf_q       <= 1'b0;
         pvf_q      <= 1'b0;
         nf_q       <= 1'b0;
         cf_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q        <= acc;
                  b_q        <= {db_in_high, db_in_low};
                  op_q       <= op543;
                  shift_q    <= shift_mode;
                  cf_shift_q <= cf_shift;
                  cf_in_q    <= cf_in;
                  busy_q     <= 1'b1;
                  state_q    <= ST_LOW;
                  if (!HOLD_RES) begin
                     result_q <= '0;
                     sf_q     <= 1'b0;
                     zf_q     <= 1'b0;
                     hf_q     <= 1'b0;
                     pvf_q    <= 1'b0;
                     nf_q     <= 1'b0;
                     cf_q     <= 1'b0;
                  end
               end
            end
            ST_LOW: begin
               lo_sum_q <= add_sum;
               c4_q     <= add_cout;
               state_q  <= ST_HIGH;
            end
            ST_HIGH: begin
               if (wr_res_d) begin
                  result_q <= res_d;
               end
               sf_q    <= sf_d;
               zf_q    <= zf_d;
               hf_q    <= hf_d;
               pvf_q   <= pvf_d;
               nf_q    <= nf_d;
               cf_q    <= cf_d;
               done_q  <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign sf     = sf_q;
   assign zf     = zf_q;
   assign hf     = hf_q;
   assign pvf    = pvf_q;
   assign nf     = nf_q;
   assign cf     = cf_q;

endmodule

// File: tb/tb_alu_nibble_core.sv
// Bench for alu_nibble_core: directed corner cases plus random ops against an
// arithmetic reference model of the Z80 8-bit ALU group.
module tb_alu_nibble_core;

   import alu_pkg::*;

   logic       clk;
   logic       nreset;
   logic       start;
   logic [2:0] op543;
   logic       shift_mode;
   logic [7:0] acc;
   logic [3:0] db_in_low;
   logic [3:0] db_in_high;
   logic       cf_shift;
   logic       cf_in;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       sf, zf, hf, pvf, nf, cf;

   int         n_checks;
   int         n_errors;
   logic [7:0] model_res;

   alu_nibble_core #(
      .NIB_W    (4),
      .HOLD_RES (1'b1)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .start      (start),
      .op543      (op543),
      .shift_mode (shift_mode),
      .acc        (acc),
      .db_in_low  (db_in_low),
      .db_in_high (db_in_high),
      .cf_shift   (cf_shift),
      .cf_in      (cf_in),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .sf         (sf),
      .zf         (zf),
      .hf         (hf),
      .pvf        (pvf),
      .nf         (nf),
      .cf         (cf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer arithmetic, flags from their textbook definitions
   task automatic ref_model(input logic [2:0] op, input logic sm, input logic [7:0] a,
                            input logic [7:0] b, input logic cfs, input logic cfi,
                            output logic [7:0] er, output logic [5:0] ef);
      int ua, ub, sa, sb, k, r, sr;
      logic [7:0] v;
      logic s, z, h, p, n, c;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      k  = 0;
      if (sm) begin
         v = b; c = cfs; h = 1'b0; n = 1'b0; p = ~(^v);
      end else begin
         case (op)
            OP_ADD, OP_ADC: begin
               if (op == OP_ADC && cfi) k = 1;
               r  = ua + ub + k;
               v  = r[7:0];
               c  = (r > 255);
               h  = (((ua % 16) + (ub % 16) + k) > 15);
               sr = sa + sb + k;
               p  = (sr > 127) || (sr < -128);
               n  = 1'b0;
            end
            OP_SUB, OP_SBC, OP_CP: begin
               if (op == OP_SBC && cfi) k = 1;
               r  = ua - ub - k;
               v  = r[7:0];
               c  = (r < 0);
               h  = (((ua % 16) - (ub % 16) - k) < 0);
               sr = sa - sb - k;
               p  = (sr > 127) || (sr < -128);
               n  = 1'b1;
            end
            default: begin
               if (op == OP_AND)      v = a & b;
               else if (op == OP_XOR) v = a ^ b;
               else                   v = a | b;
               h = (op == OP_AND);
               c = 1'b0;
               n = 1'b0;
               p = ~(^v);
            end
         endcase
      end
      s = v[7];
      z = (v == 8'h00);
      if (!sm && op == OP_CP) begin
         er = model_res;
      end else begin
         er        = v;
         model_res = v;
      end
      ef = {s, z, h, p, n, c};
   endtask

   task automatic scramble_inputs();
      op543      = 3'($urandom);
      shift_mode = 1'($urandom);
      acc        = 8'($urandom);
      db_in_low  = 4'($urandom);
      db_in_high = 4'($urandom);
      cf_shift   = 1'($urandom);
      cf_in      = 1'($urandom);
   endtask

   task automatic drive_op(input logic [2:0] op, input logic sm, input logic [7:0] a,
                           input logic [7:0] b, input logic cfs, input logic cfi);
      start      = 1'b1;
      op543      = op;
      shift_mode = sm;
      acc        = a;
      {db_in_high, db_in_low} = b;
      cf_shift   = cfs;
      cf_in      = cfi;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic sm,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic cfs, input logic cfi);
      logic [7:0] er;
      logic [5:0] ef;
      int lat;
      ref_model(op, sm, a, b, cfs, cfi, er, ef);
      @(negedge clk);
      drive_op(op, sm, a, b, cfs, cfi);
      @(posedge clk); #1;
      start = 1'b0;
      scramble_inputs();
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      lat = 0;
      while (!done && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(2));
      chk({tag, "_res"}, 32'(result), 32'(er));
      chk({tag, "_flags"}, 32'({sf, zf, hf, pvf, nf, cf}), 32'(ef));
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(done), 32'(0));
      chk({tag, "_idle"}, 32'(busy), 32'(0));
   endtask

   initial begin
      logic [7:0] er;
      logic [5:0] ef;
      int dones;
      n_checks  = 0;
      n_errors  = 0;
      model_res = 8'h00;

      // Reset with start held high: reset must win
      nreset = 1'b0;
      drive_op(OP_ADD, 1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_res", 32'(result), 32'(0));
      chk("rst_flags", 32'({sf, zf, hf, pvf, nf, cf}), 32'(0));
      @(negedge clk);
      start  = 1'b0;
      nreset = 1'b1;

      do_op("add_hc",   OP_ADD, 1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);
      do_op("add_ov",   OP_ADD, 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
      do_op("adc_wrap", OP_ADC, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1);
      do_op("add_wrap", OP_ADD, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
      do_op("sub_brw",  OP_SUB, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
      do_op("sbc_hb",   OP_SBC, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1);
      do_op("pre_5a",   OP_ADD, 1'b0, 8'h50, 8'h0A, 1'b0, 1'b0);
      do_op("cp_eq",    OP_CP,  1'b0, 8'h42, 8'h42, 1'b0, 1'b0);
      do_op("xor_ff",   OP_XOR, 1'b0, 8'h0F, 8'hF0, 1'b0, 1'b0);
      do_op("and_h",    OP_AND, 1'b0, 8'h3C, 8'h0F, 1'b0, 1'b1);
      do_op("or_par",   OP_OR,  1'b0, 8'h01, 8'h02, 1'b0, 1'b0);
      do_op("shift",    OP_SUB, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b1);
      do_op("shift_c",  OP_CP,  1'b1, 8'h00, 8'h00, 1'b1, 1'b0);

      for (int i = 0; i < 150; i++) begin
         do_op("rnd", 3'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
               8'($urandom), 1'($urandom), 1'($urandom));
      end

      // start repeated during LOW and during DONE: exactly one completion
      ref_model(OP_ADD, 1'b0, 8'h21, 8'h13, 1'b0, 1'b0, er, ef);
      dones = 0;
      @(negedge clk);
      drive_op(OP_ADD, 1'b0, 8'h21, 8'h13, 1'b0, 1'b0);
      @(posedge clk); #1;
      acc = 8'hEE;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
      @(posedge clk); #1;
      if (done) begin
         dones++;
         chk("ign_res", 32'(result), 32'(er));
         chk("ign_flags", 32'({sf, zf, hf, pvf, nf, cf}), 32'(ef));
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dones++;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("ign_dones", 32'(dones), 32'(1));
      chk("ign_busy", 32'(busy), 32'(0));

      // Reset asserted while in HIGH: abort without a done pulse
      dones = 0;
      @(negedge clk);
      drive_op(OP_ADD, 1'b0, 8'h11, 8'h22, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
      nreset = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
      chk("mid_busy", 32'(busy), 32'(0));
      chk("mid_res", 32'(result), 32'(0));
      chk("mid_flags", 32'({sf, zf, hf, pvf, nf, cf}), 32'(0));
      @(negedge clk);
      nreset    = 1'b1;
      model_res = 8'h00;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      chk("mid_nodone", 32'(dones), 32'(0));

      do_op("post_cp", OP_CP, 1'b0, 8'h10, 8'h20, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
